// File: rtl/aes_state_pkg.sv
// Shared constants, byte-order mapping and parity helpers for the AES state gearbox.
package aes_state_pkg;

   localparam int STATE_W = 128;
   localparam int NBYTES  = 16;

   typedef enum logic [0:0] {COLLECT = 1'b0, HOLD = 1'b1} des_state_t;
   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} ser_state_t;

   // Stream byte n -> flat byte index; row order swaps the row/column nibbles.
   function automatic logic [3:0] flat_idx(input logic [3:0] n, input logic row_mode);
      return row_mode ? {n[1:0], n[3:2]} : n;
   endfunction

   function automatic logic even_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/aes_byte_par_chk.sv
// Per-byte even-parity generation and comparison; err flags any byte whose parity bit disagrees.
module aes_byte_par_chk
   import aes_state_pkg::*;
#(
   parameter int NB        = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic [8*NB-1:0] data,
   input  logic [NB-1:0]   par,
   output logic            err
);

   logic [NB-1:0] mism;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_byte
         assign mism[gi] = PARITY_EN ? (even_par(data[8*gi +: 8]) != par[gi]) : 1'b0;
      end
   endgenerate

   assign err = |mism;

endmodule

// File: rtl/aes_state_gearbox.sv
// Bidirectional gearbox between a 128-bit flat AES state and a LANE_W-bit beat stream,
// with column/row byte order and per-byte parity carried through both directions.
module aes_state_gearbox
   import aes_state_pkg::*;
#(
   parameter int LANE_W    = 32,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mode_row,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [LANE_W-1:0]   s_data,
   input  logic [LANE_W/8-1:0] s_par,
   output logic                st_valid,
   input  logic                st_ready,
   output logic [127:0]        st_data,
   output logic [15:0]         st_par,
   output logic                st_err,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_data,
   input  logic [15:0]         in_par,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [LANE_W-1:0]   m_data,
   output logic [LANE_W/8-1:0] m_par,
   output logic                m_last,
   output logic                m_err
);

   localparam int         LB        = LANE_W / 8;
   localparam int         BEATS     = STATE_W / LANE_W;
   localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

   // ---------------- deserialiser ----------------
   des_state_t   des_state_reg;
   logic [3:0]   s_cnt_reg;
   logic         s_mode_reg;
   logic [127:0] st_data_reg;
   logic [15:0]  st_par_reg;
   logic         s_err_reg;
   logic         s_mode;
   logic         s_fire;
   logic         s_lane_err;
   logic [3:0]   s_idx [LB];

   assign s_ready  = (des_state_reg == COLLECT);
   assign s_fire   = s_valid && s_ready;
   // Beat 0 uses the live mode pin so the whole frame follows the mode seen at its start.
   assign s_mode   = (s_cnt_reg == 4'd0) ? mode_row : s_mode_reg;
   assign st_valid = (des_state_reg == HOLD);
   assign st_data  = st_data_reg;
   assign st_par   = st_par_reg;
   assign st_err   = s_err_reg;

   aes_byte_par_chk #(.NB(LB), .PARITY_EN(PARITY_EN)) u_s_chk (
      .data (s_data),
      .par  (s_par),
      .err  (s_lane_err)
   );

   genvar gi;
   generate
      for (gi = 0; gi < LB; gi++) begin : g_s_idx
         assign s_idx[gi] = flat_idx(4'(s_cnt_reg * LB + gi), s_mode);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         des_state_reg <= COLLECT;
         s_cnt_reg     <= 4'd0;
         s_mode_reg    <= 1'b0;
         st_data_reg   <= '0;
         st_par_reg    <= '0;
         s_err_reg     <= 1'b0;
      end else begin
         case (des_state_reg)
            COLLECT: begin
               if (s_fire) begin
                  for (int j = 0; j < LB; j++) begin
                     st_data_reg[8*s_idx[j] +: 8] <= s_data[8*j +: 8];
                     st_par_reg[s_idx[j]]         <= PARITY_EN ? s_par[j] : 1'b0;
                  end
                  s_err_reg <= s_err_reg | s_lane_err;
                  if (s_cnt_reg == 4'd0) s_mode_reg <= mode_row;
                  if (s_cnt_reg == LAST_BEAT) begin
                     s_cnt_reg     <= 4'd0;
                     des_state_reg <= HOLD;
                  end else begin
                     s_cnt_reg <= s_cnt_reg + 4'd1;
                  end
               end
            end
            HOLD: begin
               if (st_ready) begin
                  des_state_reg <= COLLECT;
                  s_err_reg     <= 1'b0;
               end
            end
            default: des_state_reg <= COLLECT;
         endcase
      end
   end

   // ---------------- serialiser ----------------
   ser_state_t   ser_state_reg;
   logic [3:0]   m_cnt_reg;
   logic         m_mode_reg;
   logic [127:0] m_data_reg;
   logic [15:0]  m_par_reg;
   logic         m_err_reg;
   logic         m_fire;
   logic         load;
   logic         in_err;
   logic [3:0]   m_idx [LB];

   assign m_valid  = (ser_state_reg == SEND);
   assign m_last   = m_valid && (m_cnt_reg == LAST_BEAT);
   assign m_fire   = m_valid && m_ready;
   assign in_ready = (ser_state_reg == IDLE) || (m_fire && m_last);
   assign load     = in_valid && in_ready;
   assign m_err    = m_err_reg;

   aes_byte_par_chk #(.NB(NBYTES), .PARITY_EN(PARITY_EN)) u_in_chk (
      .data (in_data),
      .par  (in_par),
      .err  (in_err)
   );

   generate
      for (gi = 0; gi < LB; gi++) begin : g_m_lane
         assign m_idx[gi]          = flat_idx(4'(m_cnt_reg * LB + gi), m_mode_reg);
         assign m_data[8*gi +: 8]  = m_data_reg[8*m_idx[gi] +: 8];
         assign m_par[gi]          = m_par_reg[m_idx[gi]];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ser_state_reg <= IDLE;
         m_cnt_reg     <= 4'd0;
         m_mode_reg    <= 1'b0;
         m_data_reg    <= '0;
         m_par_reg     <= '0;
         m_err_reg     <= 1'b0;
      end else if (load) begin
         // A load on the last-beat accept restarts at beat 0 with no bubble.
         ser_state_reg <= SEND;
         m_cnt_reg     <= 4'd0;
         m_mode_reg    <= mode_row;
         m_data_reg    <= in_data;
         m_par_reg     <= PARITY_EN ? in_par : 16'd0;
         m_err_reg     <= in_err;
      end else if (m_fire) begin
         if (m_last) begin
            ser_state_reg <= IDLE;
            m_cnt_reg     <= 4'd0;
         end else begin
            m_cnt_reg <= m_cnt_reg + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_aes_state_gearbox.sv
// Scoreboard bench for aes_state_gearbox with LANE_W=32: directed states, hand-computed beats.
`timescale 1ns/1ps
module tb_aes_state_gearbox;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         mode_row = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = '0;
   logic [3:0]   s_par = '0;
   logic         st_valid;
   logic         st_ready = 1'b0;
   logic [127:0] st_data;
   logic [15:0]  st_par;
   logic         st_err;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [15:0]  in_par = '0;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic [31:0]  m_data;
   logic [3:0]   m_par;
   logic         m_last;
   logic         m_err;

   aes_state_gearbox #(.LANE_W(32), .PARITY_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .mode_row(mode_row),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_par(s_par),
      .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data), .st_par(st_par), .st_err(st_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_par(in_par),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_par(m_par),
      .m_last(m_last), .m_err(m_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit m_stall = 1'b0;
   bit st_stall = 1'b0;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  par;
      logic        last;
      logic        err;
   } ser_exp_t;

   typedef struct packed {
      logic [127:0] data;
      logic [15:0]  par;
      logic         err;
   } des_exp_t;

   ser_exp_t ser_q[$];
   des_exp_t des_q[$];

   localparam logic [127:0] V1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] V2 = 128'h0f0e0d0c0b0a09080706050403020100;

   logic [31:0] v1_col [4] = '{32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
   logic [31:0] v1_row [4] = '{32'h3377bbff, 32'h2266aaee, 32'h115599dd, 32'h004488cc};
   logic [31:0] v2_col [4] = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c};
   logic [31:0] v2_row [4] = '{32'h0c080400, 32'h0d090501, 32'h0e0a0602, 32'h0f0b0703};

   function automatic logic [15:0] flat_par(input logic [127:0] d);
      logic [15:0] p;
      for (int i = 0; i < 16; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   function automatic logic [3:0] lane_par(input logic [31:0] w);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ^w[8*i +: 8];
      return p;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic ser_send(input logic [127:0] d, input logic mode,
                           input logic [31:0] beats [4], input int flip);
      logic [15:0] p;
      ser_exp_t    e;
      bit          done;
      p = flat_par(d);
      if (flip >= 0) p[flip] = ~p[flip];
      for (int b = 0; b < 4; b++) begin
         e.data = beats[b];
         for (int j = 0; j < 4; j++) e.par[j] = p[mode ? (4*j + b) : (4*b + j)];
         e.last = (b == 3);
         e.err  = (flip >= 0);
         ser_q.push_back(e);
      end
      in_valid = 1'b1;
      in_data  = d;
      in_par   = p;
      mode_row = mode;
      done     = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL ser_load_timeout actual=in_ready_low required=in_ready_high");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic des_send(input logic mode, input logic [31:0] beats [4], input logic [127:0] exp_d,
                           input int flip_n, input int nbeats, input bit push);
      des_exp_t e;
      bit       done;
      int       gap;
      e.data = exp_d;
      e.par  = flat_par(exp_d);
      if (flip_n >= 0) begin
         if (mode) e.par[4*(flip_n % 4) + flip_n / 4] = ~e.par[4*(flip_n % 4) + flip_n / 4];
         else      e.par[flip_n] = ~e.par[flip_n];
      end
      e.err = (flip_n >= 0);
      if (push) des_q.push_back(e);
      mode_row = mode;
      for (int b = 0; b < nbeats; b++) begin
         s_valid = 1'b0;
         gap = st_stall ? $urandom_range(0, 1) : 0;
         repeat (gap) begin @(posedge clk); #1; end
         s_valid = 1'b1;
         s_data  = beats[b];
         s_par   = lane_par(beats[b]);
         if (flip_n >= 0 && flip_n / 4 == b) s_par[flip_n % 4] = ~s_par[flip_n % 4];
         done = 1'b0;
         for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
         end
         if (!done) begin
            checks++; errors++;
            $display("FAIL des_beat_timeout actual=s_ready_low required=s_ready_high");
         end
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 2000 && (ser_q.size() != 0 || des_q.size() != 0); k++) @(negedge clk);
      check("ser_queue_empty", 128'(ser_q.size()), 128'd0);
      check("des_queue_empty", 128'(des_q.size()), 128'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         m_ready  = m_stall  ? 1'($urandom_range(0, 1)) : 1'b1;
         st_ready = st_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every accepted output.
   always @(negedge clk) begin : monitor
      ser_exp_t se;
      des_exp_t de;
      if (rst_n) begin
         if (m_valid && m_ready) begin
            if (ser_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL ser_unexpected actual=%h required=no_beat", m_data);
            end else begin
               se = ser_q.pop_front();
               $display("ser beat data=%h par=%h last=%b err=%b", m_data, m_par, m_last, m_err);
               check("m_data", 128'(m_data), 128'(se.data));
               check("m_par",  128'(m_par),  128'(se.par));
               check("m_last", 128'(m_last), 128'(se.last));
               check("m_err",  128'(m_err),  128'(se.err));
            end
         end
         if (st_valid && st_ready) begin
            if (des_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL des_unexpected actual=%h required=no_state", st_data);
            end else begin
               de = des_q.pop_front();
               $display("des state data=%h par=%h err=%b", st_data, st_par, st_err);
               check("st_data", st_data,         de.data);
               check("st_par",  128'(st_par),    128'(de.par));
               check("st_err",  128'(st_err),    128'(de.err));
            end
         end
         if (st_valid) check("s_ready_in_hold", 128'(s_ready), 128'd0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_s_ready",  128'(s_ready),  128'd1);
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_st_valid", 128'(st_valid), 128'd0);
      check("rst_m_valid",  128'(m_valid),  128'd0);
      check("rst_st_err",   128'(st_err),   128'd0);
      check("rst_m_err",    128'(m_err),    128'd0);
      check("rst_st_data",  st_data,        128'd0);
      @(posedge clk); #1;

      // Serialiser: column, row, corrupted parity, with random m_ready stalls.
      m_stall = 1'b1;
      ser_send(V1, 1'b0, v1_col, -1);
      ser_send(V1, 1'b1, v1_row, -1);
      ser_send(V1, 1'b0, v1_col, 5);
      drain();

      // Back-to-back frames with in_valid held high and no stalls.
      m_stall = 1'b0;
      @(posedge clk); #1;
      fork
         begin
            ser_send(V1, 1'b0, v1_col, -1);
            ser_send(V2, 1'b0, v2_col, -1);
         end
         begin
            found = 1'b0;
            for (int k = 0; k < 50 && !found; k++) begin
               @(negedge clk);
               if (m_valid) found = 1'b1;
            end
            check("b2b_start", 128'(found), 128'd1);
            for (int i = 0; i < 8; i++) begin
               check("b2b_m_valid",  128'(m_valid),  128'd1);
               check("b2b_in_ready", 128'(in_ready), 128'(i == 3 || i == 7));
               if (i < 7) @(negedge clk);
            end
         end
      join
      drain();

      // Deserialiser loopback with bubbles and st_ready stalls, then a parity fault frame.
      st_stall = 1'b1;
      des_send(1'b0, v1_col, V1, -1, 4, 1'b1);
      des_send(1'b1, v1_row, V1, -1, 4, 1'b1);
      des_send(1'b1, v2_row, V2, -1, 4, 1'b1);
      des_send(1'b0, v2_col, V2, 5, 4, 1'b1);
      des_send(1'b0, v1_col, V1, -1, 4, 1'b1);
      drain();

      // Reset in the middle of a frame, then a clean frame.
      st_stall = 1'b0;
      des_send(1'b0, v1_col, V1, -1, 2, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_s_ready",  128'(s_ready),  128'd1);
      check("midrst_st_valid", 128'(st_valid), 128'd0);
      @(posedge clk); #1;
      des_send(1'b0, v2_col, V2, -1, 4, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
